// File: rtl/adder_err_monitor.sv
// adder_err_monitor
//
// Error-evaluation stage for an approximate W-bit adder with a (W+1)-bit
// result. Each accepted sample is compared against the exact sum, and the
// error distance (ED) is accumulated into count, sum, and max statistics over
// a run of n_target samples. Results are held in DONE until the next start.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (clears everything)
//   start      : run start pulse, honoured in IDLE or DONE
//   n_target   : samples per run, latched on an accepted start
//   in_valid   : sample present this cycle
//   in_a/in_b  : operands (bit W-1 is the MSB)
//   in_sum     : approximate result (bit W is the carry out)
//   busy       : high in RUN and DRAIN
//   done       : high in DONE
//   n_samples  : samples accepted (saturating)
//   err_count  : samples with nonzero ED (saturating)
//   err_sum    : sum of ED (saturating)
//   err_max    : largest ED seen
//   max_a/b    : operands of the first sample reaching err_max
//
// Pipeline: input capture -> ED register -> accumulate. A sample accepted at
// edge t shows in the statistics after edge t+2, which is exactly when the
// two DRAIN cycles end and done rises.

module adder_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_target,
    input  logic             in_valid,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] err_sum,
    output logic [W:0]       err_max,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b
);

    // Accumulator width wide enough for err_sum + ed without wrapping.
    localparam int AW = ((SUM_W > W + 1) ? SUM_W : W + 1) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;
    localparam logic [W:0]       ED_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             drain_cnt;

    logic start_ok;
    logic accept;
    logic reach;

    // Stage 0: captured sample
    logic         s0_valid;
    logic [W-1:0] s0_a;
    logic [W-1:0] s0_b;
    logic [W:0]   s0_sum;

    // Stage 1: error distance
    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [W:0]   s1_ed;

    logic [W:0]    exact;
    logic [W+1:0]  diff;
    logic [W:0]    ed_c;
    logic [AW-1:0] sum_wide;
    logic [SUM_W-1:0] sum_sat;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
        accept   = (state == ST_RUN) && in_valid && (acc_cnt < target_q);
        // The equality term covers n_target = 0: leave RUN immediately.
        reach    = (state == ST_RUN) &&
                   ((acc_cnt == target_q) ||
                    (accept && ((acc_cnt + CNT_ONE) == target_q)));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)     state_next = ST_RUN;
            ST_RUN:   if (reach)     state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_next = ST_DONE;
            ST_DONE:  if (start)     state_next = ST_RUN;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    // Run bookkeeping: target latch, accepted count, drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= '0;
            acc_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
            if (start_ok) begin
                target_q <= n_target;
                acc_cnt  <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: sample capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_sum   <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_a   <= in_a;
                s0_b   <= in_b;
                s0_sum <= in_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: exact sum and |exact - approx|
    // ------------------------------------------------------------------
    always_comb begin
        exact = {1'b0, s0_a} + {1'b0, s0_b};
        diff  = {1'b0, exact} - {1'b0, s0_sum};
        // Magnitude always fits in W+1 bits, so negate only the low bits.
        ed_c  = diff[W+1] ? ((~diff[W:0]) + ED_ONE) : diff[W:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_a  <= s0_a;
                s1_b  <= s0_b;
                s1_ed <= ed_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate
    // ------------------------------------------------------------------
    always_comb begin
        sum_wide = AW'(err_sum) + AW'(s1_ed);
        sum_sat  = (sum_wide > AW'(SUM_MAX)) ? SUM_MAX : sum_wide[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            n_samples <= '0;
            err_count <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (s1_valid) begin
            if (n_samples != CNT_MAX) begin
                n_samples <= n_samples + CNT_ONE;
            end
            if ((s1_ed != '0) && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
            err_sum <= sum_sat;
            // Strictly greater: a tie keeps the first sample's operands.
            if (s1_ed > err_max) begin
                err_max <= s1_ed;
                max_a   <= s1_a;
                max_b   <= s1_b;
            end
        end
    end

endmodule

// File: tb/tb_adder_err_monitor.sv
// Testbench for adder_err_monitor: table of single-sample vectors, directed
// multi-cycle sequences, and randomized runs checked against a queue-based
// arithmetic model of the error statistics.

module tb_adder_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_target;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [8:0]  in_sum;

    logic        busy, done;
    logic [15:0] n_samples, err_count;
    logic [23:0] err_sum;
    logic [8:0]  err_max;
    logic [7:0]  max_a, max_b;

    logic        s_busy, s_done;
    logic [15:0] s_n_samples, s_err_count;
    logic [3:0]  s_err_sum;
    logic [8:0]  s_err_max;
    logic [7:0]  s_max_a, s_max_b;

    always #5 clk = ~clk;

    adder_err_monitor #(.W(8), .CNT_W(16), .SUM_W(24)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n_target(n_target),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(busy), .done(done), .n_samples(n_samples),
        .err_count(err_count), .err_sum(err_sum), .err_max(err_max),
        .max_a(max_a), .max_b(max_b)
    );

    // Narrow accumulator instance for the saturation case.
    adder_err_monitor #(.W(8), .CNT_W(16), .SUM_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .n_target(n_target),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(s_busy), .done(s_done), .n_samples(s_n_samples),
        .err_count(s_err_count), .err_sum(s_err_sum), .err_max(s_err_max),
        .max_a(s_max_a), .max_b(s_max_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        int         ed;
    } vec_t;

    vec_t vecs[10];

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [8:0] qs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        n_target = 16'(n);
        tick();
        start    = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sum   = s;
    endtask

    task automatic present(input bit gaps);
        foreach (qa[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            drive(qa[i], qb[i], qs[i]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Counts cycles after the last accepted sample until done; bounded.
    task automatic wait_done(input string name, input int exp_lat);
        int cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({name, " done latency"}, cyc, exp_lat);
    endtask

    // Expected statistics computed directly from the queued samples.
    task automatic check_model(input string name);
        int ns = 0, ec = 0, es = 0, em = 0, ma = 0, mb = 0;
        foreach (qa[i]) begin
            int ed;
            ed = int'(qa[i]) + int'(qb[i]) - int'(qs[i]);
            if (ed < 0) ed = -ed;
            ns++;
            if (ed != 0) ec++;
            es += ed;
            if (es > 24'hFFFFFF) es = 24'hFFFFFF;
            if (ed > em) begin
                em = ed;
                ma = int'(qa[i]);
                mb = int'(qb[i]);
            end
        end
        check({name, " done"},      int'(done),      1);
        check({name, " busy"},      int'(busy),      0);
        check({name, " n_samples"}, int'(n_samples), ns);
        check({name, " err_count"}, int'(err_count), ec);
        check({name, " err_sum"},   int'(err_sum),   es);
        check({name, " err_max"},   int'(err_max),   em);
        check({name, " max_a"},     int'(max_a),     ma);
        check({name, " max_b"},     int'(max_b),     mb);
    endtask

    task automatic run(input string name, input bit gaps);
        do_start(qa.size());
        present(gaps);
        wait_done(name, 2);
        check_model(name);
    endtask

    task automatic set_q1(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        qa.delete(); qb.delete(); qs.delete();
        qa.push_back(a); qb.push_back(b); qs.push_back(s);
    endtask

    task automatic push_q(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        qa.push_back(a); qb.push_back(b); qs.push_back(s);
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qs.delete();
    endtask

    initial begin
        vecs[0] = '{8'h7F, 8'h01, 9'h080, 0};
        vecs[1] = '{8'h01, 8'h00, 9'h000, 1};
        vecs[2] = '{8'hFF, 8'hFF, 9'h000, 510};
        vecs[3] = '{8'h10, 8'h10, 9'h021, 1};
        vecs[4] = '{8'h00, 8'h00, 9'h1FF, 511};
        vecs[5] = '{8'hFF, 8'hFF, 9'h1FE, 0};
        vecs[6] = '{8'h80, 8'h80, 9'h000, 256};
        vecs[7] = '{8'h0F, 8'hF0, 9'h0FE, 1};
        vecs[8] = '{8'h55, 8'hAA, 9'h1FF, 256};
        vecs[9] = '{8'h00, 8'h01, 9'h000, 1};

        rst = 1'b1; start = 1'b0; n_target = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
        tick(); tick();
        check("reset busy",      int'(busy),      0);
        check("reset done",      int'(done),      0);
        check("reset n_samples", int'(n_samples), 0);
        check("reset err_count", int'(err_count), 0);
        check("reset err_sum",   int'(err_sum),   0);
        check("reset err_max",   int'(err_max),   0);
        check("reset max_a",     int'(max_a),     0);
        check("reset max_b",     int'(max_b),     0);
        rst = 1'b0;
        tick();

        // Single-sample table
        for (int i = 0; i < 10; i++) begin
            set_q1(vecs[i].a, vecs[i].b, vecs[i].s);
            run("vec", 1'b0);
            check("vec table err_sum",   int'(err_sum),   vecs[i].ed);
            check("vec table err_count", int'(err_count), (vecs[i].ed != 0) ? 1 : 0);
        end

        // Exact stream
        clear_q();
        push_q(8'h7F, 8'h01, 9'h080);
        push_q(8'h00, 8'h00, 9'h000);
        push_q(8'hFF, 8'hFF, 9'h1FE);
        push_q(8'h12, 8'h34, 9'h046);
        run("exact", 1'b0);
        check("exact n_samples", int'(n_samples), 4);
        check("exact err_count", int'(err_count), 0);
        check("exact err_sum",   int'(err_sum),   0);

        // Known errors
        clear_q();
        push_q(8'h01, 8'h00, 9'h000);
        push_q(8'hFF, 8'hFF, 9'h000);
        push_q(8'h10, 8'h10, 9'h021);
        run("known", 1'b0);
        check("known err_count", int'(err_count), 3);
        check("known err_sum",   int'(err_sum),   512);
        check("known err_max",   int'(err_max),   510);
        check("known max_a",     int'(max_a),     8'hFF);
        check("known max_b",     int'(max_b),     8'hFF);

        // Tie and cap: later valid samples carry a large ED and must be dropped
        do_start(2);
        drive(8'h02, 8'h03, 9'h000); tick();
        drive(8'h04, 8'h01, 9'h000); tick();
        drive(8'hFF, 8'hFF, 9'h000);
        repeat (10) tick();
        in_valid = 1'b0;
        check("cap done",      int'(done),      1);
        check("cap n_samples", int'(n_samples), 2);
        check("cap err_sum",   int'(err_sum),   10);
        check("cap err_max",   int'(err_max),   5);
        check("tie max_a",     int'(max_a),     8'h02);
        check("tie max_b",     int'(max_b),     8'h03);

        // n_target = 0: done exactly 3 cycles after start, stats cleared
        do_start(0);
        drive(8'hFF, 8'h00, 9'h000);
        tick();
        check("zero done c1", int'(done), 0);
        tick();
        check("zero done c2", int'(done), 0);
        tick();
        in_valid = 1'b0;
        check("zero done c3",   int'(done),      1);
        check("zero n_samples", int'(n_samples), 0);
        check("zero err_count", int'(err_count), 0);
        check("zero err_sum",   int'(err_sum),   0);
        check("zero err_max",   int'(err_max),   0);

        // Narrow accumulator saturation
        clear_q();
        push_q(8'h09, 8'h00, 9'h000);
        push_q(8'h09, 8'h00, 9'h000);
        run("sat", 1'b0);
        check("sat err_sum",   int'(s_err_sum),   15);
        check("sat err_count", int'(s_err_count), 2);

        // start during RUN is ignored
        clear_q();
        push_q(8'h20, 8'h01, 9'h000);
        push_q(8'h03, 8'h03, 9'h006);
        push_q(8'h40, 8'h40, 9'h0C0);
        push_q(8'h01, 8'h01, 9'h001);
        do_start(4);
        drive(qa[0], qb[0], qs[0]); tick();
        drive(qa[1], qb[1], qs[1]); tick();
        start = 1'b1; n_target = 16'd1;
        drive(qa[2], qb[2], qs[2]); tick();
        start = 1'b0;
        drive(qa[3], qb[3], qs[3]); tick();
        in_valid = 1'b0;
        wait_done("restart", 2);
        check_model("restart");

        // Reset mid-run, in-flight samples lost
        do_start(5);
        drive(8'hFF, 8'hFF, 9'h000); tick();
        drive(8'h80, 8'h00, 9'h000); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst busy",      int'(busy),      0);
        check("midrst done",      int'(done),      0);
        check("midrst n_samples", int'(n_samples), 0);
        check("midrst err_sum",   int'(err_sum),   0);
        check("midrst err_max",   int'(err_max),   0);
        repeat (3) tick();
        check("midrst flush n_samples", int'(n_samples), 0);
        check("midrst flush busy",      int'(busy),      0);
        set_q1(8'h03, 8'h04, 9'h000);
        run("post_rst", 1'b0);
        check("post_rst err_sum", int'(err_sum), 7);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 12);
            clear_q();
            for (int k = 0; k < n; k++) begin
                logic [7:0] a, b;
                logic [8:0] s;
                a = 8'($urandom);
                b = 8'($urandom);
                s = {1'b0, a} + {1'b0, b};
                if ($urandom_range(0, 1) == 1) s = s ^ 9'($urandom_range(1, 511));
                push_q(a, b, s);
            end
            run("rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_err_monitor.md
# adder_err_monitor

Sequential error-evaluation stage placed directly downstream of an 8-bit-operand / 9-bit-result approximate adder under test. Each cycle it takes the operand pair and the adder's 9-bit result, computes the exact sum and the error distance, and accumulates error statistics over a programmable number of samples. Results are held for readout until the next run is started.

## Interface
Parameters:
- `W`, 8, operand width; the result width is `W+1`.
- `CNT_W`, 16, width of the sample counters.
- `SUM_W`, 24, width of the error-distance accumulator.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `n_target`  in  CNT_W  — number of samples in the run; latched on an accepted `start`.
- `in_valid`  in  1  — the sample is present this cycle.
- `in_a`  in  W  — operand A. Bit W-1 is the MSB and is driven by the adder's first operand-A input.
- `in_b`  in  W  — operand B, with the same ordering as `in_a`.
- `in_sum`  in  W+1  — approximate result. Bit W is the carry output; bit 0 is the adder's constant-zero LSB output.
- `busy`  out  1  — high in RUN and DRAIN.
- `done`  out  1  — high in DONE.
- `n_samples`  out  CNT_W  — number of samples accepted.
- `err_count`  out  CNT_W  — number of samples with a nonzero error distance.
- `err_sum`  out  SUM_W  — sum of error distances; saturating.
- `err_max`  out  W+1  — largest error distance seen.
- `max_a`, `max_b`  out  W  — operands of the first sample that reached `err_max`.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN and DONE.
  - IDLE → RUN on `start`. The same edge clears all statistics and latches `n_target`.
  - DONE → RUN on `start`, with the same clear and latch.
  - RUN → DRAIN on the edge where the accepted-sample count reaches `n_target`.
  - If `n_target`=0, RUN → DRAIN on the first RUN cycle, with no sample accepted.
  - DRAIN stays for exactly 2 cycles, then goes to DONE.
  - DONE holds all outputs until `start` or `rst`.
- A sample is accepted when `in_valid` is high in RUN and fewer than `n_target` samples have been accepted. The cap holds even when `in_valid` is held high continuously.
- Any `in_valid` outside RUN is ignored.
- `start` in RUN or DRAIN is ignored; it neither restarts nor clears.
- Pipeline stage 1 (registered):
  - `exact = in_a + in_b`, computed at W+1 bits with no loss.
  - `ed = |exact − in_sum|`, computed at W+2 bits signed and then truncated to W+1 bits. The truncation is lossless, since the maximum is 2^(W+1)−1.
  - The stage also carries `in_a`, `in_b` and a valid flag.
- Pipeline stage 2 (accumulate):
  - `n_samples` += 1.
  - `err_count` += (`ed` ≠ 0).
  - `err_sum` += `ed`, saturating at 2^SUM_W−1.
  - If `ed` > `err_max` (strictly greater), then `err_max` ← `ed` and `max_a`/`max_b` ← the sample's operands. On a tie the first occurrence is kept.
- `n_samples` and `err_count` saturate at 2^CNT_W−1. `n_target` bounds them, so they saturate only if `n_target` = all-ones.
- `rst` takes priority over everything. The block returns to IDLE, clears every output and flushes the pipeline valids, even in the middle of a run; samples in flight are lost.

## Timing
- Reset values: `busy`=0, `done`=0, and all statistic outputs are 0.
- A `start` sampled at edge k puts the block in RUN from cycle k+1. A sample presented in cycle k+1 with `in_valid` is accepted.
- A sample accepted at edge t is reflected in the statistic outputs after edge t+2, which is two cycles of latency.
- RUN throughput is one sample per cycle, with no backpressure.
- After the last sample is accepted at edge t:
  - DRAIN is entered at t and lasts through t+2.
  - `done` rises after edge t+2, in the same cycle in which the last sample's contribution is visible.
  - `busy` falls in that same cycle.
- With `n_target`=0, `done` rises 3 cycles after `start` and all statistics read 0.
- While `busy` is high the statistic outputs are live (intermediate values); they are final only while `done` is high.

## Test plan
- Exact stream: 4 samples with the correct 9-bit sum (for example a=0x7F, b=0x01, sum=0x080), `n_target`=4 → `n_samples`=4, `err_count`=0, `err_sum`=0, `err_max`=0, and `done` rises 2 cycles after the last accepted sample.
- Known errors, `n_target`=3:
  - a=0x01, b=0x00, sum=0x000 → ed 1.
  - a=0xFF, b=0xFF, sum=0x000 → ed 510.
  - a=0x10, b=0x10, sum=0x021 → ed 1.
  - Expected: `err_count`=3, `err_sum`=512, `err_max`=510, `max_a`=0xFF, `max_b`=0xFF.
- Tie and cap:
  - Inputs: two samples each with ed 5 (first a=0x02, b=0x03; second a=0x04, b=0x01), followed by `in_valid` held high for 10 more cycles, with `n_target`=2.
  - Expected: `max_a`=0x02, `max_b`=0x03, and `n_samples`=2 (the extra samples are ignored).
- `n_target`=0 → `done` 3 cycles after `start`, all statistics 0.
- With `SUM_W`=4: samples with ed 9 and then ed 9 → `err_sum`=15 (saturated), `err_count`=2.
- Control and reset:
  - `start` pulsed during RUN → has no effect on the statistics.
  - `rst` asserted mid-run → next cycle IDLE, all outputs 0.
  - A following `start` with a 1-sample run → correct fresh results.
